// File: rtl/alu_result_collector.sv
// Captures one tagged ALU result per cycle into a show-ahead FIFO drained over valid/ready.
// Arith results are sign-extended, the other units are zero-extended, and drops/conflicts are sticky.
module alu_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Arith_flag,
    input  logic                  Logic_flag,
    input  logic                  CMP_flag,
    input  logic                  SHIFT_flag,
    input  logic signed [15:0]    Arith_OUT,
    input  logic [7:0]            Logic_OUT,
    input  logic [1:0]            CMP_OUT,
    input  logic [7:0]            SHIFT_OUT,
    input  logic                  out_ready,
    input  logic                  clr_ovf,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [1:0]            res_tag,
    output logic [CNT_WIDTH-1:0]  fifo_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  flag_conflict
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        TAG_ARITH = 2'b00,
        TAG_LOGIC = 2'b01,
        TAG_CMP   = 2'b10,
        TAG_SHIFT = 2'b11
    } tag_e;

    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    tag_e                  tag_mem_q  [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic                 conf_q, conf_d;

    logic                  push, pop, wr_en, drop, conflict_now;
    logic [DATA_WIDTH-1:0] in_data;
    tag_e                  in_tag;

    assign push = Arith_flag | Logic_flag | CMP_flag | SHIFT_flag;
    assign conflict_now = (Arith_flag & (Logic_flag | CMP_flag | SHIFT_flag))
                        | (Logic_flag & (CMP_flag | SHIFT_flag))
                        | (CMP_flag & SHIFT_flag);

    // Fixed priority Arith > Logic > CMP > SHIFT
    always_comb begin
        in_data = '0;
        in_tag  = TAG_ARITH;
        if (Arith_flag) begin
            in_data = DATA_WIDTH'(Arith_OUT);
            in_tag  = TAG_ARITH;
        end else if (Logic_flag) begin
            in_data = DATA_WIDTH'(Logic_OUT);
            in_tag  = TAG_LOGIC;
        end else if (CMP_flag) begin
            in_data = DATA_WIDTH'(CMP_OUT);
            in_tag  = TAG_CMP;
        end else if (SHIFT_flag) begin
            in_data = DATA_WIDTH'(SHIFT_OUT);
            in_tag  = TAG_SHIFT;
        end
    end

    assign pop   = valid_q & out_ready;
    assign wr_en = push & (~full_q | pop);
    assign drop  = push & full_q & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
        full_d  = (count_d == CNT_WIDTH'(DEPTH));
        // A new event in the same cycle as a clear keeps the flag set
        ovf_d   = (ovf_q & ~clr_ovf) | drop;
        conf_d  = (conf_q & ~clr_ovf) | conflict_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            conf_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            conf_q   <= conf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            data_mem_q[wr_ptr_q] <= in_data;
            tag_mem_q[wr_ptr_q]  <= in_tag;
        end
    end

    assign res_valid     = valid_q;
    assign res_data      = valid_q ? data_mem_q[rd_ptr_q] : '0;
    assign res_tag       = valid_q ? tag_mem_q[rd_ptr_q] : TAG_ARITH;
    assign fifo_count    = count_q;
    assign full          = full_q;
    assign overflow      = ovf_q;
    assign flag_conflict = conf_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed and randomized bench for alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              Arith_flag, Logic_flag, CMP_flag, SHIFT_flag;
    logic signed [15:0] Arith_OUT;
    logic [7:0]        Logic_OUT;
    logic [1:0]        CMP_OUT;
    logic [7:0]        SHIFT_OUT;
    logic              out_ready, clr_ovf;
    logic              res_valid;
    logic [DW-1:0]     res_data;
    logic [1:0]        res_tag;
    logic [CW-1:0]     fifo_count;
    logic              full, overflow, flag_conflict;

    int checks = 0;
    int errors = 0;

    // Reference model: each entry is {tag, data}
    logic [17:0] mq[$];
    bit          m_ovf, m_conf;

    alu_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .Arith_flag(Arith_flag), .Logic_flag(Logic_flag), .CMP_flag(CMP_flag), .SHIFT_flag(SHIFT_flag),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .fifo_count(fifo_count), .full(full), .overflow(overflow), .flag_conflict(flag_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [17:0] head;
        head = (mq.size() > 0) ? mq[0] : 18'h0;
        chk({ctx, ".valid"}, 32'(res_valid), 32'(mq.size() > 0));
        chk({ctx, ".data"}, 32'(res_data), 32'(head[15:0]));
        chk({ctx, ".tag"}, 32'(res_tag), 32'(head[17:16]));
        chk({ctx, ".count"}, 32'(fifo_count), 32'(mq.size()));
        chk({ctx, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({ctx, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({ctx, ".conf"}, 32'(flag_conflict), 32'(m_conf));
    endtask

    // f = {Arith, Logic, CMP, SHIFT}
    task automatic step(input string ctx, input bit r, input bit [3:0] f,
                        input logic [15:0] ao, input logic [7:0] lo, input logic [1:0] co,
                        input logic [7:0] so, input bit rdy, input bit clr);
        int          nflags;
        bit          do_pop, had_room, new_ovf;
        logic [17:0] w;
        rst = r;
        {Arith_flag, Logic_flag, CMP_flag, SHIFT_flag} = f;
        Arith_OUT = ao; Logic_OUT = lo; CMP_OUT = co; SHIFT_OUT = so;
        out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf  = 0;
            m_conf = 0;
        end else begin
            nflags   = int'(f[3]) + int'(f[2]) + int'(f[1]) + int'(f[0]);
            do_pop   = (mq.size() > 0) && rdy;
            had_room = mq.size() < DEPTH;
            if (f[3])      w = {2'd0, ao};
            else if (f[2]) w = {2'd1, 8'h00, lo};
            else if (f[1]) w = {2'd2, 14'h0, co};
            else           w = {2'd3, 8'h00, so};
            new_ovf = 0;
            if (do_pop) void'(mq.pop_front());
            if (nflags > 0) begin
                if (had_room || do_pop) mq.push_back(w);
                else new_ovf = 1;
            end
            m_ovf  = (m_ovf && !clr) || new_ovf;
            m_conf = (m_conf && !clr) || (nflags > 1);
        end
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input bit rdy, input bit clr);
        step(ctx, 1'b0, 4'b0000, 16'h0, 8'h0, 2'h0, 8'h0, rdy, clr);
    endtask

    initial begin
        rst = 1'b1;
        {Arith_flag, Logic_flag, CMP_flag, SHIFT_flag} = 4'b0;
        Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; SHIFT_OUT = '0;
        out_ready = 1'b0; clr_ovf = 1'b0;
        m_ovf = 0; m_conf = 0;

        // Reset
        step("rst0", 1'b1, 4'b0000, 16'h0, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        step("rst1", 1'b1, 4'b0000, 16'h0, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        chk("rst_data", 32'(res_data), 32'h0);

        // Arith -8 sign-extended, 1-cycle latency
        step("t2", 1'b0, 4'b1000, 16'hFFF8, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        chk("t2_data", 32'(res_data), 32'h0000FFF8);
        chk("t2_tag", 32'(res_tag), 32'h0);

        // Fill with four units, then overflow and clear
        step("rst2", 1'b1, 4'b0000, 16'h0, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        step("p_log", 1'b0, 4'b0100, 16'h0, 8'h65, 2'h0, 8'h0, 1'b0, 1'b0);
        step("p_cmp", 1'b0, 4'b0010, 16'h0, 8'h0, 2'h3, 8'h0, 1'b0, 1'b0);
        step("p_sh", 1'b0, 4'b0001, 16'h0, 8'h0, 2'h0, 8'h4A, 1'b0, 1'b0);
        step("p_ar", 1'b0, 4'b1000, 16'd27, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        chk("t3_full", 32'(full), 32'h1);
        step("ovf", 1'b0, 4'b1000, 16'hFFF4, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        chk("t4_ovf", 32'(overflow), 32'h1);
        chk("t4_count", 32'(fifo_count), 32'd4);
        idle("clr", 1'b0, 1'b1);
        chk("t4_clr", 32'(overflow), 32'h0);

        chk("pop0", 32'({res_tag, res_data}), 32'h10065);
        idle("pop0", 1'b1, 1'b0);
        chk("pop1", 32'({res_tag, res_data}), 32'h20003);
        idle("pop1", 1'b1, 1'b0);
        chk("pop2", 32'({res_tag, res_data}), 32'h3004A);
        idle("pop2", 1'b1, 1'b0);
        chk("pop3", 32'({res_tag, res_data}), 32'h0001B);
        idle("pop3", 1'b1, 1'b0);
        chk("empty_data", 32'(res_data), 32'h0);

        // Full with simultaneous push and pop, then conflicting flags
        for (int i = 0; i < DEPTH; i++)
            step("refill", 1'b0, 4'b1000, 16'(i + 1), 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        step("full_pp", 1'b0, 4'b1000, 16'd100, 8'h0, 2'h0, 8'h0, 1'b1, 1'b0);
        chk("t5_count", 32'(fifo_count), 32'd4);
        chk("t5_noovf", 32'(overflow), 32'h0);
        step("conf", 1'b0, 4'b0101, 16'h0, 8'h5C, 2'h0, 8'hA7, 1'b1, 1'b0);
        chk("t5_conf", 32'(flag_conflict), 32'h1);
        for (int i = 0; i < DEPTH; i++) idle("drain", 1'b1, 1'b0);
        idle("clr2", 1'b0, 1'b1);

        // Mid-stream reset discards entries
        step("two0", 1'b0, 4'b0100, 16'h0, 8'h11, 2'h0, 8'h0, 1'b0, 1'b0);
        step("two1", 1'b0, 4'b0100, 16'h0, 8'h22, 2'h0, 8'h0, 1'b0, 1'b0);
        step("rst3", 1'b1, 4'b0000, 16'h0, 8'h0, 2'h0, 8'h0, 1'b0, 1'b0);
        chk("t6_count", 32'(fifo_count), 32'd0);

        // Pointer wrap with steady push/pop
        step("wrap_pre", 1'b0, 4'b0001, 16'h0, 8'h0, 2'h0, 8'hC0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++)
            step("wrap", 1'b0, 4'b0001, 16'h0, 8'(8'hC1 + i), 2'h0, 8'h0, 1'b1, 1'b0);
        idle("wrap_end", 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [3:0] f;
            f[3] = ($urandom_range(0, 3) == 0);
            f[2] = ($urandom_range(0, 2) == 0);
            f[1] = ($urandom_range(0, 2) == 0);
            f[0] = ($urandom_range(0, 2) == 0);
            step("rand", ($urandom_range(0, 99) == 0), f, 16'($urandom), 8'($urandom),
                 2'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
